// File: rtl/l1_refill_ctrl.sv
// L1 miss-handling controller: write-through stores, line refill over a req/ack memory bus.
// Optional build macro L1_REFILL_CRIT_WORD_FIRST_EN fetches the requested word first.
module l1_refill_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_valid,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_w_data,
  input  logic                    cache_hit,
  output logic                    cpu_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_r_data,
  output logic                    fill_en,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [LINE_SIZE*8-1:0]  fill_data,
  output logic                    fill_mark_valid
);

  localparam int unsigned WordsPerLine = LINE_SIZE * 8 / DATA_WIDTH;
  localparam int unsigned IdxW         = (WordsPerLine > 1) ? $clog2(WordsPerLine) : 1;
  localparam int unsigned ByteOffW     = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LineOffW     = $clog2(LINE_SIZE);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StFill} state_e;

  state_e                                   state_q;
  logic [IdxW-1:0]                          word_idx_q;
  logic [IdxW-1:0]                          beat_q;
  logic [ADDR_WIDTH-1:0]                    line_base_q;
  logic [WordsPerLine-1:0][DATA_WIDTH-1:0]  line_buf_q;

  logic [WordsPerLine-1:0][DATA_WIDTH-1:0]  line_buf_merged;
  logic [ADDR_WIDTH-1:0]                    line_base_in;
  logic [IdxW-1:0]                          start_idx;
  logic [IdxW-1:0]                          word_idx_next;
  logic                                     ack_valid;
  logic                                     last_beat;

  assign line_base_in  = cpu_addr & ~ADDR_WIDTH'(LINE_SIZE - 1);
  assign word_idx_next = word_idx_q + IdxW'(1);
  assign ack_valid     = mem_ack & mem_req;
  assign last_beat     = (beat_q == IdxW'(WordsPerLine - 1));

`ifdef L1_REFILL_CRIT_WORD_FIRST_EN
  assign start_idx = IdxW'(cpu_addr[LineOffW-1:ByteOffW]);
`else
  assign start_idx = '0;
`endif

  // Word slot follows the fetch index, so the line layout is order-independent.
  always_comb begin
    line_buf_merged             = line_buf_q;
    line_buf_merged[word_idx_q] = mem_r_data;
  end

  assign cpu_stall = (state_q != StIdle) | (cpu_valid & (cpu_we | ~cache_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      word_idx_q      <= '0;
      beat_q          <= '0;
      line_base_q     <= '0;
      line_buf_q      <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_w_data      <= '0;
      fill_en         <= 1'b0;
      fill_addr       <= '0;
      fill_data       <= '0;
      fill_mark_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          fill_en         <= 1'b0;
          fill_mark_valid <= 1'b0;
          if (cpu_valid && cpu_we) begin
            state_q    <= StWrite;
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= cpu_addr;
            mem_w_data <= cpu_w_data;
          end else if (cpu_valid && !cache_hit) begin
            state_q     <= StRead;
            line_base_q <= line_base_in;
            word_idx_q  <= start_idx;
            beat_q      <= '0;
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= line_base_in | (ADDR_WIDTH'(start_idx) << ByteOffW);
          end
        end
        StWrite: begin
          if (ack_valid) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        StRead: begin
          if (ack_valid) begin
            line_buf_q <= line_buf_merged;
            word_idx_q <= word_idx_next;
            beat_q     <= beat_q + IdxW'(1);
            if (last_beat) begin
              state_q         <= StFill;
              mem_req         <= 1'b0;
              fill_en         <= 1'b1;
              fill_mark_valid <= 1'b1;
              fill_addr       <= line_base_q;
              fill_data       <= line_buf_merged;
            end else begin
              // Next word is presented the cycle after each ack.
              mem_addr <= line_base_q | (ADDR_WIDTH'(word_idx_next) << ByteOffW);
            end
          end
        end
        StFill: begin
          state_q         <= StIdle;
          fill_en         <= 1'b0;
          fill_mark_valid <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
          fill_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed self-checking bench for l1_refill_ctrl (default or critical-word-first build).
module tb_l1_refill_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid, cpu_we, cache_hit, cpu_stall;
  logic [31:0]   cpu_addr, cpu_w_data;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, mem_w_data, mem_r_data;
  logic          fill_en, fill_mark_valid;
  logic [31:0]   fill_addr;
  logic [127:0]  fill_data;

  int n_cmp  = 0;
  int n_fail = 0;

  l1_refill_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LINE_SIZE (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_valid      (cpu_valid),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_w_data     (cpu_w_data),
    .cache_hit      (cache_hit),
    .cpu_stall      (cpu_stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_w_data     (mem_w_data),
    .mem_ack        (mem_ack),
    .mem_r_data     (mem_r_data),
    .fill_en        (fill_en),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .fill_mark_valid(fill_mark_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    cpu_valid  = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h0;
    cpu_w_data = 32'h0;
    cache_hit  = 1'b0;
    mem_ack    = 1'b0;
    mem_r_data = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    step();
    step();
    n_cmp++;
    if ({mem_req, mem_we, fill_en, fill_mark_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0000", {mem_req, mem_we, fill_en, fill_mark_valid});
    end
    n_cmp++;
    if ({mem_addr, mem_w_data, fill_addr} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h %h %h want 0", mem_addr, mem_w_data, fill_addr);
    end
    n_cmp++;
    if (fill_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_fill_data: got %h want 0", fill_data);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++;
    if (cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b want 0", cpu_stall);
    end
  endtask

  task automatic test_reset_mid_read();
    int bad;
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h3008;
    cache_hit = 1'b0;
    step();
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midread_req_up: got %b want 1", mem_req);
    end
    mem_ack    = 1'b1;
    mem_r_data = 32'h55;
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, fill_en, fill_mark_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midread_async_drop: got %b want 0000", {mem_req, mem_we, fill_en, fill_mark_valid});
    end
    n_cmp++;
    if ({mem_addr, fill_addr} !== 64'h0 || fill_data !== 128'h0) begin
      n_fail++;
      $display("FAIL midread_regs_clear: got %h %h %h want 0", mem_addr, fill_addr, fill_data);
    end
    drive_idle();
    #1;
    n_cmp++;
    if (cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_state_idle: stall got %b want 0", cpu_stall);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fill_en !== 1'b0 || mem_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midread_no_fill_after: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_load_miss(input logic [31:0] addr, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] e3, input logic [31:0] base);
    logic [31:0]  got [4];
    logic [31:0]  exp_a [4];
    logic [31:0]  f_addr;
    logic [127:0] f_data;
    logic         f_mv;
    int stall_cnt, fills, nreq, we_err;
    bit done;
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
    for (int i = 0; i < 4; i++) got[i] = 32'hX;
    stall_cnt = 0; fills = 0; nreq = 0; we_err = 0; done = 1'b0;
    f_addr = 32'hX; f_data = 128'hX; f_mv = 1'bX;
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = addr;
    cache_hit = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      if (mem_req === 1'b1) begin
        if (nreq < 4) got[nreq] = mem_addr;
        nreq++;
        if (mem_we !== 1'b0) we_err++;
        mem_ack    = 1'b1;
        mem_r_data = 32'hA0 + {30'd0, mem_addr[3:2]};
      end else begin
        mem_ack = 1'b0;
      end
      if (fill_en === 1'b1) begin
        fills++;
        f_addr    = fill_addr;
        f_data    = fill_data;
        f_mv      = fill_mark_valid;
        cache_hit = 1'b1;
      end
      #1;
      if (cpu_stall === 1'b1) stall_cnt++;
      else done = 1'b1;
      if (!done) step();
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL miss_%h_timeout: stall still high after 30 cycles", addr);
    end
    drive_idle();
    step();
    n_cmp++;
    if (stall_cnt !== 6) begin
      n_fail++;
      $display("FAIL miss_%h_stall_cycles: got %0d want 6", addr, stall_cnt);
    end
    n_cmp++;
    if (nreq !== 4 || we_err !== 0) begin
      n_fail++;
      $display("FAIL miss_%h_req_count: got %0d reqs %0d we errs want 4 0", addr, nreq, we_err);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL miss_%h_addr%0d: got %h want %h", addr, i, got[i], exp_a[i]);
      end
    end
    n_cmp++;
    if (fills !== 1 || f_mv !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_%h_fill_pulse: got %0d pulses mark %b want 1 1", addr, fills, f_mv);
    end
    n_cmp++;
    if (f_addr !== base) begin
      n_fail++;
      $display("FAIL miss_%h_fill_addr: got %h want %h", addr, f_addr, base);
    end
    n_cmp++;
    if (f_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_fail++;
      $display("FAIL miss_%h_fill_data: got %h want 000000a3000000a2000000a1000000a0", addr, f_data);
    end
  endtask

  task automatic test_store();
    int stall_cnt, nreq, attr_err, fills;
    bit done;
    stall_cnt = 0; nreq = 0; attr_err = 0; fills = 0; done = 1'b0;
    cpu_valid  = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 32'h2004;
    cpu_w_data = 32'hDEADBEEF;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      if (mem_req === 1'b1) begin
        nreq++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h2004 || mem_w_data !== 32'hDEADBEEF) attr_err++;
        // The CPU bus wanders while stalled; the latched copy must win.
        cpu_addr   = 32'hFFFF_FFF0;
        cpu_w_data = 32'h0;
        mem_ack    = (nreq == 4);
        if (nreq == 4) cpu_valid = 1'b0;
      end else begin
        mem_ack = 1'b0;
      end
      if (fill_en === 1'b1) fills++;
      #1;
      if (cpu_stall === 1'b1) stall_cnt++;
      else done = 1'b1;
      if (!done) step();
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL store_timeout: stall still high after 30 cycles");
    end
    n_cmp++;
    if (stall_cnt !== 5) begin
      n_fail++;
      $display("FAIL store_stall_cycles: got %0d want 5", stall_cnt);
    end
    n_cmp++;
    if (nreq !== 4) begin
      n_fail++;
      $display("FAIL store_req_cycles: got %0d want 4", nreq);
    end
    n_cmp++;
    if (attr_err !== 0) begin
      n_fail++;
      $display("FAIL store_attrs: got %0d bad cycles want 0", attr_err);
    end
    n_cmp++;
    if (fills !== 0) begin
      n_fail++;
      $display("FAIL store_no_fill: got %0d pulses want 0", fills);
    end
    n_cmp++;
    if ({mem_req, mem_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_req_drop: got %b want 00", {mem_req, mem_we});
    end
    drive_idle();
    step();
  endtask

  task automatic test_load_hit();
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h1004;
    cache_hit = 1'b1;
    #1;
    n_cmp++;
    if (cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_stall: got %b want 0", cpu_stall);
    end
    step();
    n_cmp++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_no_req: got req %b stall %b want 0 0", mem_req, cpu_stall);
    end
    drive_idle();
    step();
  endtask

  task automatic test_spurious_ack();
    int bad;
    bad = 0;
    drive_idle();
    mem_ack    = 1'b1;
    mem_r_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req !== 1'b0 || fill_en !== 1'b0 || cpu_stall !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL spurious_ack: got %0d disturbed cycles want 0", bad);
    end
    drive_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
`ifdef L1_REFILL_CRIT_WORD_FIRST_EN
    test_load_miss(32'h1008, 32'h1008, 32'h100C, 32'h1000, 32'h1004, 32'h1000);
    test_load_miss(32'h400C, 32'h400C, 32'h4000, 32'h4004, 32'h4008, 32'h4000);
`else
    test_load_miss(32'h1008, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1000);
    test_load_miss(32'h400C, 32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4000);
`endif
    test_store();
    test_load_hit();
    test_spurious_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
